sram_arbiter_nx1: RTL and testbench

Parametrised N-master to 1-slave arbiter for the sram-like bus (req/wr/size/addr/wdata → addr_ok/data_ok/rdata). It generalises the fixed two-way data-path merge in front of cpu_axi_interface. Any number of masters (icache, dcache, uncached data, future TLB walker) share one port. It tracks up to MAX_OUTST in-flight transactions and routes each data_ok back to the master that issued it. Arbitration is either fixed-priority or round-robin.

---
 rtl/sram_bus_pkg.sv | 16 +
 rtl/route_fifo.sv | 56 +++++
 rtl/sram_arbiter_nx1.sv | 120 ++++++++++++
 tb/tb_sram_arbiter_nx1.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared encodings and helpers for the sram-like bus arbiter.
package sram_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a master id; never zero so a single-bit id still exists.
  function automatic int id_w(input int n_masters);
    return (n_masters > 1) ? $clog2(n_masters) : 1;
  endfunction

endpackage

// File: rtl/route_fifo.sv
// Synchronous FIFO of master ids: remembers who owns each in-flight transaction.
module route_fifo
  import sram_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] din,
  input  logic            pop,
  output logic [ID_W-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Id storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_arbiter_nx1.sv
// N-master to 1-slave sram-bus arbiter with in-order response routing.
module sram_arbiter_nx1
  import sram_bus_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_wr,
  input  logic [2*N_MASTERS-1:0]        m_size,
  input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
  input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_addr_ok,
  output logic [N_MASTERS-1:0]          m_data_ok,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_wr,
  output logic [1:0]                    s_size,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [$clog2(MAX_OUTST):0]    outst_cnt,
  output logic                          err_orphan
);

  localparam int IDW   = id_w(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic           lock_q;
  logic [IDW-1:0] lock_id_q;
  logic [IDW-1:0] rr_ptr_q;
  logic           lock_hold;
  logic [IDW-1:0] grant_free;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] head_id;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           resp;
  logic           orphan;

  // Free-running arbitration: fixed priority or round-robin from rr_ptr.
  always_comb begin
    int  idx;
    logic found;
    grant_free = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = (ARB_MODE == ARB_RR) ? ((int'(rr_ptr_q) + i) % N_MASTERS) : i;
      if (!found && m_req[idx]) begin
        found      = 1'b1;
        grant_free = IDW'(idx);
      end
    end
  end

  // A lock only holds while its master keeps requesting; a dropped request releases it.
  assign lock_hold = lock_q & m_req[lock_id_q];
  assign grant     = lock_hold ? lock_id_q : grant_free;

  assign s_req   = (|m_req) & ~fifo_full;
  assign s_wr    = m_wr[grant];
  assign s_size  = m_size[grant*2 +: 2];
  assign s_addr  = m_addr[grant*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[grant*DATA_W +: DATA_W];

  assign accept  = s_req & s_addr_ok;
  assign resp    = s_data_ok & ~fifo_empty;
  assign orphan  = s_data_ok & fifo_empty;
  assign m_rdata = s_rdata;

  // One-hot accept and response pulses, both combinational on the slave handshake.
  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    if (accept) m_addr_ok[grant]   = 1'b1;
    if (resp)   m_data_ok[head_id] = 1'b1;
  end

  route_fifo #(
    .DEPTH (MAX_OUTST),
    .ID_W  (IDW),
    .CNT_W (CNT_W)
  ) u_route_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (grant),
    .pop   (resp),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outst_cnt)
  );

  // Lock, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      rr_ptr_q   <= '0;
      err_orphan <= 1'b0;
    end else begin
      lock_q <= s_req & ~s_addr_ok;
      if (s_req && !s_addr_ok) lock_id_q <= grant;
      if (accept && (ARB_MODE == ARB_RR))
        rr_ptr_q <= (grant == IDW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter_nx1.sv
// Self-checking bench: scoreboard of expected response owners for the arbiter.
module tb_sram_arbiter_nx1;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    m_req;
  logic [N-1:0]    m_wr;
  logic [2*N-1:0]  m_size;
  logic [AW*N-1:0] m_addr;
  logic [DW*N-1:0] m_wdata;
  logic            s_addr_ok, s_data_ok;
  logic [DW-1:0]   s_rdata;

  logic [N-1:0]    m_addr_ok, m_data_ok;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_wr;
  logic [1:0]      s_size;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [2:0]      outst_cnt;
  logic            err_orphan;

  logic [N-1:0]    m_addr_ok_f, m_data_ok_f;
  logic [DW-1:0]   m_rdata_f;
  logic            s_req_f, s_wr_f;
  logic [1:0]      s_size_f;
  logic [AW-1:0]   s_addr_f;
  logic [DW-1:0]   s_wdata_f;
  logic [2:0]      outst_cnt_f;
  logic            err_orphan_f;

  logic [31:0] addr_tab [N];
  logic        wr_tab   [N];

  int   exp_q [$];
  int   total = 0;
  int   bad   = 0;
  int   fix_exp = -1;
  logic exp_err = 1'b0;

  sram_arbiter_nx1 #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .ARB_MODE(1)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outst_cnt(outst_cnt), .err_orphan(err_orphan)
  );

  sram_arbiter_nx1 #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .ARB_MODE(0)) dut_fix (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok_f), .m_data_ok(m_data_ok_f), .m_rdata(m_rdata_f),
    .s_req(s_req_f), .s_wr(s_wr_f), .s_size(s_size_f), .s_addr(s_addr_f), .s_wdata(s_wdata_f),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outst_cnt(outst_cnt_f), .err_orphan(err_orphan_f)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample comb outputs 1 time unit later.
  // g = expected granted master (-1: s_req must be low).
  task automatic cyc(input logic [2:0] req, input logic ok, input logic dok,
                     input logic [31:0] rd, input int g);
    int         id;
    logic [2:0] oh;
    @(negedge clk);
    m_req     = req;
    s_addr_ok = ok;
    s_data_ok = dok;
    s_rdata   = rd;
    #1;
    chk("outst_cnt", 64'(outst_cnt), 64'(exp_q.size()));
    chk("err_orphan", 64'(err_orphan), 64'(exp_err));
    if (g >= 0) begin
      chk("s_req", 64'(s_req), 64'd1);
      chk("s_addr", 64'(s_addr), 64'(addr_tab[g]));
      chk("s_wr", 64'(s_wr), 64'(wr_tab[g]));
    end else begin
      chk("s_req_low", 64'(s_req), 64'd0);
    end
    if (dok) begin
      if (exp_q.size() > 0) begin
        id = exp_q.pop_front();
        oh = 3'b001 << id;
        chk("m_data_ok", 64'(m_data_ok), 64'(oh));
        chk("m_rdata", 64'(m_rdata), 64'(rd));
      end else begin
        chk("m_data_ok_orphan", 64'(m_data_ok), 64'd0);
        exp_err = 1'b1;
      end
    end else begin
      chk("m_data_ok_idle", 64'(m_data_ok), 64'd0);
    end
    if (ok && g >= 0) begin
      oh = 3'b001 << g;
      chk("m_addr_ok", 64'(m_addr_ok), 64'(oh));
      exp_q.push_back(g);
    end else begin
      chk("m_addr_ok_idle", 64'(m_addr_ok), 64'd0);
    end
    if (fix_exp >= 0 && ok) begin
      oh = 3'b001 << fix_exp;
      chk("fixed_grant", 64'(m_addr_ok_f), 64'(oh));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    m_req     = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    addr_tab[0] = 32'h0000_1000;
    addr_tab[1] = 32'h1FC0_0000;
    addr_tab[2] = 32'h0000_2000;
    wr_tab[0] = 1'b0;
    wr_tab[1] = 1'b0;
    wr_tab[2] = 1'b1;
    m_addr  = {addr_tab[2], addr_tab[1], addr_tab[0]};
    m_wr    = {wr_tab[2], wr_tab[1], wr_tab[0]};
    m_size  = {3{2'd2}};
    m_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    rst = 1'b1;
    m_req = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // reset state, then single-master read from master 1
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
    cyc(3'b010, 1'b1, 1'b0, 32'h0, 1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
    cyc(3'b000, 1'b0, 1'b1, 32'hDEADBEEF, -1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);

    // round-robin fairness; fixed-priority instance must always pick master 0
    do_reset();
    fix_exp = 0;
    cyc(3'b111, 1'b1, 1'b0, 32'h0, 0);
    for (int k = 1; k < 6; k++)
      cyc(3'b111, 1'b1, 1'b1, 32'h1000 + 32'(k), k % 3);
    fix_exp = -1;
    cyc(3'b000, 1'b0, 1'b1, 32'h2000, -1);

    // lock: master 2 held three cycles while master 0 joins
    cyc(3'b100, 1'b0, 1'b0, 32'h0, 2);
    cyc(3'b101, 1'b0, 1'b0, 32'h0, 2);
    cyc(3'b101, 1'b0, 1'b0, 32'h0, 2);
    cyc(3'b101, 1'b1, 1'b0, 32'h0, 2);
    cyc(3'b001, 1'b1, 1'b0, 32'h0, 0);
    cyc(3'b000, 1'b0, 1'b1, 32'h3001, -1);
    cyc(3'b000, 1'b0, 1'b1, 32'h3002, -1);

    // full: four accepts, then blocked until the cycle after a response
    cyc(3'b111, 1'b1, 1'b0, 32'h0, 1);
    cyc(3'b111, 1'b1, 1'b0, 32'h0, 2);
    cyc(3'b111, 1'b1, 1'b0, 32'h0, 0);
    cyc(3'b111, 1'b1, 1'b0, 32'h0, 1);
    cyc(3'b111, 1'b1, 1'b0, 32'h0, -1);
    cyc(3'b111, 1'b1, 1'b1, 32'h4001, -1);
    cyc(3'b111, 1'b1, 1'b0, 32'h0, 2);
    for (int k = 0; k < 4; k++)
      cyc(3'b000, 1'b0, 1'b1, 32'h4100 + 32'(k), -1);

    // interleave with a simultaneous accept and response
    cyc(3'b001, 1'b1, 1'b0, 32'h0, 0);
    cyc(3'b100, 1'b1, 1'b0, 32'h0, 2);
    cyc(3'b010, 1'b1, 1'b1, 32'h5000, 1);
    cyc(3'b000, 1'b0, 1'b1, 32'h5002, -1);
    cyc(3'b000, 1'b0, 1'b1, 32'h5001, -1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);

    // reset with two in flight, then an orphan response
    cyc(3'b001, 1'b1, 1'b0, 32'h0, 0);
    cyc(3'b010, 1'b1, 1'b0, 32'h0, 1);
    do_reset();
    cyc(3'b000, 1'b0, 1'b1, 32'h6000, -1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
    do_reset();
    cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
